// File: rtl/alu_acc_unit.sv
// WIDTH-bit accumulator ALU that takes operand B from a shared tri-state bus.
// Define ALU_MUL_EN to build the iterative shift-add multiplier (opcode 111, BUSY state).
module alu_acc_unit #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] ACC_RESET = '0
) (
    input  logic             clk,
    input  logic             Rst,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [2:0]       opcode,
    input  logic             oe,
    inout  wire  [WIDTH-1:0] data_bus,
    output logic [WIDTH-1:0] acc,
    output logic             carry,
    output logic             zero,
    output logic             done,
    output logic             dbg_busy
);

    // Handshake: an operation is taken at a rising edge where op_valid && op_ready.
    // op_ready is high only in IDLE; anything offered while it is low is dropped, not queued.

    localparam logic [2:0] OP_LOAD = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b100;
    localparam logic [2:0] OP_XOR  = 3'b101;
    localparam logic [2:0] OP_CMP  = 3'b110;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] b_in;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic             accept;

`ifdef ALU_MUL_EN
    localparam int             CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] prod_sum;
`endif

    assign data_bus = oe ? acc_q : {WIDTH{1'bz}};

    always_comb begin
        b_in    = data_bus;
        sum     = {1'b0, acc_q} + {1'b0, b_in};
        diff    = {1'b0, acc_q} - {1'b0, b_in};
        accept  = op_valid && (state_q == IDLE);
        state_d = state_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        zero_d  = zero_q;
        done_d  = 1'b0;
`ifdef ALU_MUL_EN
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        prod_sum = prod_q + (mplier_q[0] ? mcand_q : '0);
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    done_d = 1'b1;
                    case (opcode)
                        OP_LOAD: begin
                            acc_d   = b_in;
                            carry_d = 1'b0;
                            zero_d  = (b_in == '0);
                        end
                        OP_ADD: begin
                            acc_d   = sum[WIDTH-1:0];
                            carry_d = sum[WIDTH];
                            zero_d  = (sum[WIDTH-1:0] == '0);
                        end
                        OP_SUB: begin
                            acc_d   = diff[WIDTH-1:0];
                            carry_d = diff[WIDTH];
                            zero_d  = (diff[WIDTH-1:0] == '0);
                        end
                        OP_AND: begin
                            acc_d   = acc_q & b_in;
                            carry_d = 1'b0;
                            zero_d  = ((acc_q & b_in) == '0);
                        end
                        OP_OR: begin
                            acc_d   = acc_q | b_in;
                            carry_d = 1'b0;
                            zero_d  = ((acc_q | b_in) == '0);
                        end
                        OP_XOR: begin
                            acc_d   = acc_q ^ b_in;
                            carry_d = 1'b0;
                            zero_d  = ((acc_q ^ b_in) == '0);
                        end
                        OP_CMP: begin
                            carry_d = diff[WIDTH];
                            zero_d  = (diff[WIDTH-1:0] == '0);
                        end
                        default: begin
`ifdef ALU_MUL_EN
                            // Result and done wait for the last partial product.
                            done_d   = 1'b0;
                            state_d  = BUSY;
                            mcand_d  = {{WIDTH{1'b0}}, acc_q};
                            mplier_d = b_in;
                            prod_d   = '0;
                            cnt_d    = '0;
`endif
                        end
                    endcase
                end
            end
            BUSY: begin
`ifdef ALU_MUL_EN
                prod_d   = prod_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    acc_d   = prod_sum[WIDTH-1:0];
                    carry_d = |prod_sum[2*WIDTH-1:WIDTH];
                    zero_d  = (prod_sum[WIDTH-1:0] == '0);
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            state_q  <= IDLE;
            acc_q    <= ACC_RESET;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef ALU_MUL_EN
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            done_q   <= done_d;
`ifdef ALU_MUL_EN
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign op_ready = (state_q == IDLE);
    assign dbg_busy = (state_q == BUSY);
    assign acc      = acc_q;
    assign carry    = carry_q;
    assign zero     = zero_q;
    assign done     = done_q;

endmodule

// File: doc/alu_acc_unit.md
# alu_acc_unit

Parametrised accumulator ALU with a tri-state bus port, successor to the fixed 4-bit ALU/bus-driver pairing on the data bus. Holds a WIDTH-bit accumulator and registered carry/zero flags, samples operand B from the shared data bus under a valid/ready handshake, and can drive the accumulator back onto the bus. An optional iterative multiplier adds a multi-cycle BUSY state.

## Interface
- WIDTH, 4: datapath width in bits; legal range 2..16.
- ACC_RESET, 0: accumulator value loaded on reset, WIDTH bits.

- clk  input  1  rising-edge clock.
- Rst  input  1  asynchronous reset, active-low (Rst=0 resets).
- op_valid  input  1  opcode and bus operand are presented.
- op_ready  output  1  unit can accept an operation this cycle.
- opcode  input  3  operation select, see Operation.
- oe  input  1  drive accumulator onto data_bus when 1.
- data_bus  inout  WIDTH  shared bus; operand B source; Z when oe=0.
- acc  output  WIDTH  accumulator register.
- carry  output  1  registered carry/borrow flag.
- zero  output  1  registered zero flag.
- done  output  1  one-cycle pulse after a result is committed.

## Operation
- Accept: op_valid & op_ready at a rising edge. B = data_bus sampled at that edge, A = current acc.
- Opcodes (result width WIDTH, wraps mod 2^WIDTH):
  - 000 LOAD: acc<=B; carry<=0.
  - 001 ADD: acc<=A+B; carry<=bit WIDTH of the (WIDTH+1)-bit sum.
  - 010 SUB: acc<=A-B; carry<=1 iff A<B unsigned (borrow).
  - 011 AND, 100 OR, 101 XOR: bitwise; carry<=0.
  - 110 CMP: flags as SUB; acc unchanged.
  - 111 MUL: see Configuration.
- zero<=1 iff the computed result (the SUB result for CMP) equals 0.
- Bus driver: data_bus=acc while oe=1, else all-Z. oe is independent of state; when oe=1 at accept, B=acc (self-operand).
- FSM: IDLE, BUSY. op_ready=1 only in IDLE. Single-cycle ops stay in IDLE. MUL goes IDLE->BUSY on accept and returns to IDLE on the last iteration edge.
- Ops presented while op_ready=0 are ignored (no queuing); opcode/data_bus changes during BUSY have no effect.

## Timing
- Reset (Rst=0, asynchronous, any state): acc=ACC_RESET, carry=0, zero=0, done=0, state=IDLE, op_ready=1 once Rst=1. Reset during BUSY aborts MUL without committing.
- Single-cycle op accepted at edge k: acc/carry/zero update at edge k; done=1 for cycle k..k+1; op_ready remains 1 (back-to-back accepts every cycle allowed, done held high continuously).
- MUL accepted at edge k: op_ready=0 from edge k to edge k+WIDTH; acc/flags update at edge k+WIDTH; done=1 for the single following cycle; next accept possible at edge k+WIDTH+1.
- data_bus drive follows oe combinationally; acc change at an edge appears on the bus in the same cycle when oe=1.

## Configuration
- ALU_MUL_EN defined: opcode 111 = unsigned shift-add multiply, one partial product per cycle, WIDTH cycles. acc<=low WIDTH bits of A*B; carry<=1 iff high WIDTH bits nonzero; zero on low half.
- ALU_MUL_EN undefined: no BUSY state is built; opcode 111 is a single-cycle NOP: acc, carry, zero unchanged; done still pulses one cycle later.

## Test plan
- Reset: WIDTH=4, ACC_RESET=4'h3, Rst pulsed low mid-cycle -> acc=0011, carry=0, zero=0, done=0, op_ready=1 immediately (asynchronous).
- Load/ADD wrap: LOAD B=1111, then ADD B=0001 -> acc=0000, carry=1, zero=1, done high for each of the two cycles.
- SUB/CMP: acc=0001, CMP B=0101 -> acc stays 0001, carry=1, zero=0; SUB B=0001 -> acc=0000, carry=0, zero=1.
- Bus self-operand: acc=0101, oe=1, XOR accepted -> data_bus read 0101, acc=0000, zero=1; oe=0 -> data_bus=zzzz.
- MUL (ALU_MUL_EN, WIDTH=4): acc=0110, MUL B=0011 -> op_ready low 4 cycles, acc=0010, carry=1, zero=0, done one cycle; op_valid held during BUSY with other opcodes ignored.
- Reset mid-MUL: Rst low in 2nd BUSY cycle -> acc=ACC_RESET, no done pulse, IDLE; without ALU_MUL_EN opcode 111 leaves acc/flags unchanged, done pulses.
